// File: rtl/cache_xbar_arb.sv
// Round-robin N-to-1 arbiter sharing one downstream cache port, grant held per request ID.
// Optional watchdog on held grants is enabled with CACHE_ARB_WDOG_EN.
module cache_xbar_arb #(
    parameter int prt = 2,
    parameter int blk = 64,
    parameter int tmo = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    flmask,
    input  logic [7:0]                    flrqst,
    input  logic [prt-1:0][7:0]           s_rqst,
    input  logic [prt-1:0][7:0]           s_trsc,
    input  logic [prt-1:0][blk-1:0]       s_strb,
    input  logic [prt-1:0][63:0]          s_addr,
    input  logic [prt-1:0][blk*8-1:0]     s_wdat,
    output logic [prt-1:0][7:0]           s_resp,
    output logic [prt-1:0][7:0]           s_miss,
    output logic [prt-1:0][63:0]          s_ofst,
    output logic [prt-1:0][blk*8-1:0]     s_rdat,
    output logic [7:0]                    m_rqst,
    output logic [7:0]                    m_trsc,
    output logic [blk-1:0]                m_strb,
    output logic [63:0]                   m_addr,
    output logic [blk*8-1:0]              m_wdat,
    input  logic [7:0]                    m_resp,
    input  logic [7:0]                    m_miss,
    input  logic [63:0]                   m_ofst,
    input  logic [blk*8-1:0]              m_rdat,
    output logic                          wd_err
);

    localparam int PW = (prt > 1) ? $clog2(prt) : 1;

    typedef enum logic {IDLE, HOLD} st_t;

    st_t             st;
    logic [PW-1:0]   g_port;
    logic [PW-1:0]   rr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   nxt;
    logic [7:0]      g_id;
    logic [7:0]      cur;
    logic [prt-1:0]  elig;
    logic            found;
    logic            hit;
    logic            rel;
    logic            wd_fire;

    function automatic logic flushed(input logic [7:0] id,
                                     input logic [7:0] mask,
                                     input logic [7:0] rq);
        return (|id) && ((id & ~mask) == (rq & ~mask));
    endfunction

    always_comb begin
        for (int p = 0; p < prt; p++) begin
            elig[p] = (|s_rqst[p]) && !flushed(s_rqst[p], flmask, flrqst);
        end
    end

    // First eligible port at or after rr, wrapping at prt.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < prt; i++) begin
            idx = (int'(rr) + i) % prt;
            if (!found && elig[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
        nxt = (win == PW'(prt - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        cur = s_rqst[g_port];
        hit = (cur == g_id) && !flushed(g_id, flmask, flrqst);
        rel = (st == HOLD) &&
              ((m_resp == g_id) || (cur != g_id) ||
               flushed(g_id, flmask, flrqst) || wd_fire);
    end

    always_comb begin
        m_rqst = (st == HOLD && hit && !wd_fire) ? g_id : 8'h00;
        m_trsc = s_trsc[g_port];
        m_strb = s_strb[g_port];
        m_addr = s_addr[g_port];
        m_wdat = s_wdat[g_port];
    end

    always_comb begin
        for (int p = 0; p < prt; p++) begin
            s_resp[p] = m_resp;
            s_miss[p] = m_miss;
            s_ofst[p] = m_ofst;
            s_rdat[p] = m_rdat;
        end
    end

    // A release re-arbitrates in the same cycle from the already advanced rr.
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            g_port <= '0;
            g_id   <= 8'h00;
            rr     <= '0;
        end else if (st == IDLE || rel) begin
            if (found) begin
                st     <= HOLD;
                g_port <= win;
                g_id   <= s_rqst[win];
                rr     <= nxt;
            end else begin
                st     <= IDLE;
            end
        end
    end

`ifdef CACHE_ARB_WDOG_EN
    localparam logic [15:0] TMO = 16'(tmo);

    logic [15:0] cnt;

    assign wd_fire = (st == HOLD) && (cnt == TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 16'h0;
            wd_err <= 1'b0;
        end else begin
            if (st == IDLE || rel) cnt <= 16'h0;
            else                   cnt <= cnt + 16'h1;
            if (wd_fire) wd_err <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign wd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cache_xbar_arb.sv
// Bench for cache_xbar_arb: directed scenarios then random traffic against a reference model.
// Three ports, 8-byte lines.
module tb_cache_xbar_arb;
    localparam int P = 3;
    localparam int B = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]             flmask, flrqst;
    logic [P-1:0][7:0]      s_rqst, s_trsc;
    logic [P-1:0][B-1:0]    s_strb;
    logic [P-1:0][63:0]     s_addr;
    logic [P-1:0][B*8-1:0]  s_wdat;
    logic [P-1:0][7:0]      s_resp, s_miss;
    logic [P-1:0][63:0]     s_ofst;
    logic [P-1:0][B*8-1:0]  s_rdat;
    logic [7:0]             m_rqst, m_trsc;
    logic [B-1:0]           m_strb;
    logic [63:0]            m_addr;
    logic [B*8-1:0]         m_wdat;
    logic [7:0]             m_resp, m_miss;
    logic [63:0]            m_ofst;
    logic [B*8-1:0]         m_rdat;
    logic                   wd_err;

    cache_xbar_arb #(.prt(P), .blk(B), .tmo(8)) dut (
        .clk(clk), .rst(rst), .flmask(flmask), .flrqst(flrqst),
        .s_rqst(s_rqst), .s_trsc(s_trsc), .s_strb(s_strb),
        .s_addr(s_addr), .s_wdat(s_wdat),
        .s_resp(s_resp), .s_miss(s_miss), .s_ofst(s_ofst), .s_rdat(s_rdat),
        .m_rqst(m_rqst), .m_trsc(m_trsc), .m_strb(m_strb),
        .m_addr(m_addr), .m_wdat(m_wdat),
        .m_resp(m_resp), .m_miss(m_miss), .m_ofst(m_ofst), .m_rdat(m_rdat),
        .wd_err(wd_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference: who holds the downstream port, with which ID, and whose turn is next.
    bit         mbusy;
    int         mport;
    int         mrr;
    logic [7:0] mid;

    function automatic bit fl(input logic [7:0] id, input logic [7:0] mask,
                              input logic [7:0] rq);
        return (id != 8'h00) && ((id & ~mask) == (rq & ~mask));
    endfunction

    function automatic logic [7:0] exp_rqst();
        if (mbusy && s_rqst[mport] == mid && !fl(mid, flmask, flrqst)) return mid;
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_checks();
        logic [7:0] e;
        e = exp_rqst();
        chk("m_rqst", 64'(m_rqst), 64'(e));
        if (e != 8'h00) begin
            chk("m_addr", m_addr, s_addr[mport]);
            chk("m_wdat", 64'(m_wdat), 64'(s_wdat[mport]));
            chk("m_trsc", 64'(m_trsc), 64'(s_trsc[mport]));
            chk("m_strb", 64'(m_strb), 64'(s_strb[mport]));
        end
        for (int p = 0; p < P; p++) begin
            chk("s_resp", 64'(s_resp[p]), 64'(m_resp));
            chk("s_miss", 64'(s_miss[p]), 64'(m_miss));
            chk("s_ofst", s_ofst[p], m_ofst);
            chk("s_rdat", 64'(s_rdat[p]), 64'(m_rdat));
        end
        chk("wd_err", 64'(wd_err), 64'd0);
    endtask

    task automatic model_update();
        bit got;
        int q;
        if (rst) begin
            mbusy = 1'b0;
            mrr   = 0;
        end else if (!mbusy || m_resp == mid || s_rqst[mport] != mid ||
                     fl(mid, flmask, flrqst)) begin
            got = 1'b0;
            for (int k = 0; k < P; k++) begin
                q = (mrr + k) % P;
                if (!got && s_rqst[q] != 8'h00 && !fl(s_rqst[q], flmask, flrqst)) begin
                    got   = 1'b1;
                    mbusy = 1'b1;
                    mport = q;
                    mid   = s_rqst[q];
                    mrr   = (q + 1) % P;
                end
            end
            if (!got) mbusy = 1'b0;
        end
    endtask

    task automatic step(input string tag, input bit use_exp, input logic [7:0] e);
        #1;
        if (use_exp) chk(tag, 64'(m_rqst), 64'(e));
        model_checks();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        s_rqst = '0;
        m_resp = 8'h00;
        m_miss = 8'h00;
        flmask = 8'h00;
        flrqst = 8'h00;
        step("rst_a", 1'b1, 8'h00);
        step("rst_b", 1'b1, 8'h00);
        rst = 1'b0;
    endtask

    logic [7:0] t2_exp [6] = '{8'h11, 8'h11, 8'h21, 8'h21, 8'h11, 8'h11};
    logic [7:0] t2_rsp [6] = '{8'h00, 8'h11, 8'h11, 8'h21, 8'h21, 8'h11};

    initial begin
        flmask = 8'h00; flrqst = 8'h00;
        s_rqst = '0; s_trsc = '0; s_strb = '0; s_addr = '0; s_wdat = '0;
        m_resp = 8'h00; m_miss = 8'h00; m_ofst = 64'h0; m_rdat = '0;
        for (int p = 0; p < P; p++) begin
            s_addr[p] = 64'h1000 * (p + 1);
            s_wdat[p] = {32'hA5A50000 + 32'(p), 32'h0};
            s_trsc[p] = 8'(p + 3);
            s_strb[p] = 8'hF0 | 8'(p);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mbusy = 1'b0; mrr = 0; mport = 0; mid = 8'h00;
        chk("reset_idle", 64'(m_rqst), 64'd0);
        do_reset();

        // Single request: one-cycle arbitration latency, response broadcast.
        s_rqst[0] = 8'h11;
        step("t1_t0", 1'b1, 8'h00);
        m_resp = 8'h11;
        #1;
        chk("t1_resp0", 64'(s_resp[0]), 64'h11);
        chk("t1_resp1", 64'(s_resp[1]), 64'h11);
        step("t1_t1", 1'b1, 8'h11);
        s_rqst[0] = 8'h00; m_resp = 8'h00;
        step("t1_t2", 1'b1, 8'h00);
        step("t1_idle", 1'b1, 8'h00);

        // Two held requesters, downstream answers one cycle after issue.
        do_reset();
        s_rqst[0] = 8'h11; s_rqst[1] = 8'h21;
        step("t2_arb", 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) begin
            m_resp = t2_rsp[i];
            step("t2_alt", 1'b1, t2_exp[i]);
        end

        // Response with miss, later miss callback must not disturb a grant.
        do_reset();
        s_rqst[0] = 8'h11;
        step("t3_arb", 1'b1, 8'h00);
        m_resp = 8'h11; m_miss = 8'h40;
        #1;
        chk("t3_miss", 64'(s_miss[2]), 64'h40);
        step("t3_hit", 1'b1, 8'h11);
        s_rqst[0] = 8'h00; m_resp = 8'h00; m_miss = 8'h00;
        step("t3_rel", 1'b1, 8'h00);
        s_rqst[1] = 8'h21;
        step("t3_idle", 1'b1, 8'h00);
        m_resp = 8'h40;
        #1;
        chk("t3_cb_resp", 64'(s_resp[0]), 64'h40);
        chk("t3_cb_miss", 64'(s_miss[1]), 64'h00);
        step("t3_cb", 1'b1, 8'h21);
        m_resp = 8'h00;
        step("t3_keep", 1'b1, 8'h21);

        // Flush of the held 2x ID.
        s_rqst[0] = 8'h11; flmask = 8'h0f; flrqst = 8'h20;
        step("t4_flush", 1'b1, 8'h00);
        step("t4_next", 1'b1, 8'h11);
        m_resp = 8'h11;
        step("t4_resp", 1'b1, 8'h11);
        m_resp = 8'h00;
        step("t4_no2x", 1'b1, 8'h11);
        flmask = 8'h00; flrqst = 8'h00; m_resp = 8'h11;
        step("t4_unfl", 1'b1, 8'h11);
        m_resp = 8'h00;
        step("t4_21", 1'b1, 8'h21);

        // ID replacement, then reset while holding.
        do_reset();
        s_rqst[0] = 8'h11;
        step("t5_arb", 1'b1, 8'h00);
        step("t5_11", 1'b1, 8'h11);
        s_rqst[0] = 8'h12;
        step("t5_swap", 1'b1, 8'h00);
        step("t5_12", 1'b1, 8'h12);
        s_rqst[1] = 8'h21;
        step("t5_wait", 1'b1, 8'h12);
        s_rqst[0] = 8'h13;
        step("t5_swap2", 1'b1, 8'h00);
        rst = 1'b1;
        step("t5_21", 1'b1, 8'h21);
        rst = 1'b0;
        step("t5_rstd", 1'b1, 8'h00);
        step("t5_rr0", 1'b1, 8'h13);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < P; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 2) == 0) s_rqst[p] = 8'h00;
                    else s_rqst[p] = {4'(p + 1), 4'($urandom_range(1, 3))};
                end
                s_addr[p] = {$urandom, $urandom};
                s_wdat[p] = {$urandom, $urandom};
                s_trsc[p] = 8'($urandom);
                s_strb[p] = 8'($urandom);
            end
            case ($urandom_range(0, 3))
                0:       m_resp = mbusy ? mid : 8'h00;
                1:       m_resp = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))};
                default: m_resp = 8'h00;
            endcase
            m_miss = 8'($urandom);
            m_ofst = {$urandom, $urandom};
            m_rdat = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) begin
                flmask = ($urandom_range(0, 1) == 0) ? 8'h0f : 8'h00;
                flrqst = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))};
            end else if ($urandom_range(0, 3) == 0) begin
                flmask = 8'h00;
                flrqst = 8'h00;
            end
            rst = ($urandom_range(0, 49) == 0);
            step("rnd", 1'b0, 8'h00);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
